// File: rtl/switch_sequence_driver.sv
// Photonic-switch sequence driver: runs a free count against a small schedule of
// match times, toggling the switch gate on each qualified comparator match.
module switch_sequence_driver #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             counter_clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic [AW:0]      num_entries,
    input  logic [WIDTH-1:0] period,
    input  logic             repeat_mode,
    input  logic             start,
    input  logic             stop,
    input  logic             comp,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] target,
    output logic             cmp_en,
    output logic             switch_out,
    output logic [AW-1:0]    entry_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [AW-1:0]    idx_reg, idx_next;
    logic             sw_reg, sw_next;
    logic             comp_q;
    logic             match;
    logic             at_last;
    logic             sched_we;
    logic             can_start;
    logic [AW:0]      eff_entries;
    logic [WIDTH-1:0] sched [DEPTH];

    assign sched_we = load_en && (state_reg == IDLE);

    // Schedule is plain registers so the asynchronous reset can clear every entry.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sched
        logic [WIDTH-1:0] entry_reg;
        always_ff @(posedge counter_clk or negedge reset) begin
            if (!reset) begin
                entry_reg <= '0;
            end else if (sched_we && (load_addr == AW'(gi))) begin
                entry_reg <= load_data;
            end
        end
        assign sched[gi] = entry_reg;
    end

    assign eff_entries = (num_entries > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_entries;
    assign can_start   = start && (eff_entries != '0);
    // ">=" rather than "==" so a length shrunk mid-run still terminates the pass.
    assign at_last     = (({1'b0, idx_reg} + (AW+1)'(1)) >= eff_entries);
    // The comparator holds comp until the next edge; only its rising edge counts.
    assign match       = comp && !comp_q;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        idx_next   = idx_reg;
        sw_next    = sw_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (can_start) begin
                    state_next = RUN;
                    count_next = '0;
                    idx_next   = '0;
                    sw_next    = 1'b0;
                end
            end
            RUN: begin
                count_next = (count_reg == period) ? '0 : count_reg + WIDTH'(1);
                if (match) begin
                    sw_next = !sw_reg;
                    if (!at_last) begin
                        idx_next = idx_reg + AW'(1);
                    end else if (repeat_mode) begin
                        idx_next = '0;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (stop) begin
            state_next = IDLE;
            count_next = '0;
            idx_next   = '0;
            sw_next    = 1'b0;
        end
    end

    always_ff @(posedge counter_clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            idx_reg   <= '0;
            sw_reg    <= 1'b0;
            comp_q    <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            idx_reg   <= idx_next;
            sw_reg    <= sw_next;
            comp_q    <= comp;
        end
    end

    assign count      = count_reg;
    assign target     = sched[idx_reg];
    assign entry_idx  = idx_reg;
    assign switch_out = sw_reg;
    assign busy       = (state_reg == RUN);
    assign cmp_en     = (state_reg == RUN);
    assign done       = (state_reg == DONE);

endmodule

// File: doc/switch_sequence_driver.md
Name: switch_sequence_driver

Overview:
- Initiator side of the photonic-switch timing path.
- Drives the 7-bit count bus and the target value into the match comparator, and consumes its match pulse.
- Holds a small schedule of match times. Each match toggles the switch gate output and advances to the next schedule entry.
- One instance per photonic switch channel, between the control-register front end and the comparator.

Parameters:
- WIDTH, 7, width of count/target/period values (fixed match with comparator bus).
- DEPTH, 8, number of schedule entries.
- AW, 3, schedule address width (log2 DEPTH).

Ports:
- counter_clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- load_en  in  1  schedule write strobe.
- load_addr  in  AW  schedule write address.
- load_data  in  WIDTH  schedule write data (match time).
- num_entries  in  AW+1  active schedule length, 0..DEPTH.
- period  in  WIDTH  terminal count; count wraps period->0.
- repeat_mode  in  1  1 = loop schedule forever, 0 = single pass.
- start  in  1  begin sequence (level sampled at posedge).
- stop  in  1  abort sequence.
- comp  in  1  match pulse from comparator.
- count  out  WIDTH  count bus to comparator in_x.
- target  out  WIDTH  target bus to comparator in_y.
- cmp_en  out  1  comparator enable.
- switch_out  out  1  photonic switch gate.
- entry_idx  out  AW  current schedule index.
- busy  out  1  high in RUN.
- done  out  1  single-pass completion flag.

Behaviour:
- Reset values (reset low): count=0, entry_idx=0, switch_out=0, cmp_en=0, busy=0, done=0, state=IDLE, all schedule entries=0, comp_q=0.
- target = schedule[entry_idx], combinational from registered index.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - load_en writes schedule[load_addr] <= load_data at posedge. Writes are ignored in RUN and DONE.
  - start with num_entries!=0 -> RUN; count<=0, entry_idx<=0, switch_out<=0, done<=0.
  - start with num_entries==0 is ignored.
- RUN:
  - busy=1, cmp_en=1.
  - Each posedge: count <= (count==period) ? 0 : count+1. period=0 holds count at 0.
- Match detect: comp_q <= comp every posedge; match = comp & ~comp_q. The comparator holds comp until the next posedge, so the rising-edge qualification prevents double-counting one match.
- Match latency: count==target during cycle N -> comp rises combinationally -> match sampled at edge N+1. At that edge switch_out toggles and entry_idx advances.
- Schedule advance on match:
  - entry_idx < num_entries-1: entry_idx+1.
  - Last entry and repeat_mode=1: entry_idx<=0, stay in RUN; count keeps running.
  - Last entry and repeat_mode=0: -> DONE; switch_out keeps its final value.
- match seen outside RUN is ignored.
- Entries greater than period are never matched; the block waits in RUN until stop. This is not an error.
- DONE: cmp_en=0, busy=0, done=1, count holds. start -> RUN (same re-init as from IDLE); stop -> IDLE.
- stop in any state -> IDLE next edge: count=0, entry_idx=0, switch_out=0, cmp_en=0, done=0.
- start and stop in the same cycle: stop wins.
- reset low mid-RUN: immediate asynchronous clear to reset values. Schedule contents are lost.
- num_entries > DEPTH is treated as DEPTH.
- No arithmetic overflow: count width is WIDTH, and the wrap is forced at period (max 127).

Test Plan:
- Reset: hold reset low 3 cycles mid-RUN -> count=0, switch_out=0, busy=0, target=0 immediately.
- Single pass: load [5,20,40], num_entries=3, period=63, repeat=0, start.
  - switch_out rises at edge after count==5, falls after 20, rises after 40.
  - Then done=1, busy=0, cmp_en=0, entry_idx=2.
- Repeat: same schedule, repeat=1, period=49 -> switch_out toggles at count 5/20/40 in every period. After 3 periods switch_out=1 (odd toggle count) and the sequence is still busy.
- Double-count guard: model comparator holding comp 1 cycle past match -> exactly one toggle per match, entry_idx increments by 1.
- Boundaries:
  - start with num_entries=0 -> stays IDLE.
  - Entry 70 with period=63 -> no toggle after 200 cycles.
  - load_en during RUN -> schedule unchanged.
- Control conflicts:
  - start and stop asserted together -> IDLE.
  - stop at count=30 -> count=0, switch_out=0 next edge.
  - start from DONE restarts at entry 0.
